// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-main-memory arbiter.
package cache_mem_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_IDX_W      = 3;
  localparam int DEFAULT_MEM_LAT = 4;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_WRITE
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Word-aligned address of word idx inside the block starting at base
  function automatic logic [15:0] fill_addr(input logic [11:0] base,
                                            input logic [WORD_IDX_W-1:0] idx);
    return {base, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache request/response and memory request/response bundle seen by the arbiter.
interface cache_mem_arbiter_if;
  import cache_mem_pkg::*;

  logic                  i_req;
  logic [15:0]           i_addr;
  logic                  i_grant;
  logic                  i_rvalid;
  logic                  i_done;

  logic                  d_req;
  logic                  d_wr;
  logic [15:0]           d_addr;
  logic [15:0]           d_wdata;
  logic                  d_grant;
  logic                  d_rvalid;
  logic                  d_done;

  logic [15:0]           rdata;
  logic [WORD_IDX_W-1:0] rword;

  logic [15:0]           mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_en;
  logic                  mem_wr;
  logic [15:0]           mem_rdata;
  logic                  mem_data_valid;

  // The arbiter serves the caches and drives the memory request
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    output i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done, rdata, rword,
    output mem_addr, mem_wdata, mem_en, mem_wr
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    input  i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done, rdata, rword,
    input  mem_addr, mem_wdata, mem_en, mem_wr
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; remembers which side was served last.
module rr_arb2
  import cache_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_reqI,
  input  logic   i_reqD,
  input  logic   i_update,
  output owner_e o_winner,
  output logic   o_anyReq
);

  owner_e r_lastSrv;

  // On a tie the side that was not served last wins
  always_comb begin
    o_anyReq = i_reqI | i_reqD;
    o_winner = OWN_I;
    if (i_reqI && i_reqD) begin
      o_winner = (r_lastSrv == OWN_D) ? OWN_I : OWN_D;
    end else if (i_reqD) begin
      o_winner = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastSrv <= OWN_D;
    end else if (i_update) begin
      r_lastSrv <= o_winner;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shared-memory arbiter: serialises I/D cache misses into 8-word block fills and
// single-word D-cache write-through stores toward one pipelined main memory.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int MEM_LAT = DEFAULT_MEM_LAT,
  parameter int WORDS   = WORDS_PER_BLOCK
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_mem_arbiter_if.slave bus
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS - 1);

  state_e                r_state;
  owner_e                r_owner;
  logic [11:0]           r_base;
  logic [WORD_IDX_W-1:0] r_issueCnt;
  logic [WORD_IDX_W-1:0] r_recvCnt;
  logic [7:0]            r_holdCnt;
  logic                  r_memEn;
  logic                  r_memWr;
  logic [15:0]           r_memAddr;
  logic [15:0]           r_memWdata;
  logic                  r_iGrant;
  logic                  r_dGrant;
  logic                  r_wrDone;

  owner_e                w_winner;
  logic                  w_anyReq;
  logic                  w_update;
  logic [11:0]           w_selBase;
  logic [WORD_IDX_W-1:0] w_nextIssue;
  logic                  w_busy;
  logic                  w_rsp;
  logic                  w_last;

  assign w_update    = (r_state == ST_IDLE) && w_anyReq;
  assign w_selBase   = (w_winner == OWN_D) ? bus.d_addr[15:4] : bus.i_addr[15:4];
  assign w_nextIssue = r_issueCnt + 1'b1;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_reqI   (bus.i_req),
    .i_reqD   (bus.d_req),
    .i_update (w_update),
    .o_winner (w_winner),
    .o_anyReq (w_anyReq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HOLD;
      r_owner    <= OWN_I;
      r_base     <= '0;
      r_issueCnt <= '0;
      r_recvCnt  <= '0;
      r_holdCnt  <= 8'(MEM_LAT);
      r_memEn    <= 1'b0;
      r_memWr    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_iGrant   <= 1'b0;
      r_dGrant   <= 1'b0;
      r_wrDone   <= 1'b0;
    end else begin
      r_iGrant <= 1'b0;
      r_dGrant <= 1'b0;
      r_wrDone <= 1'b0;
      case (r_state)
        // Let responses to requests issued before reset fall out of the memory
        ST_HOLD: begin
          if (r_holdCnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_holdCnt <= r_holdCnt - 8'd1;
          end
        end
        ST_IDLE: begin
          if (w_anyReq) begin
            r_owner    <= w_winner;
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
            r_memEn    <= 1'b1;
            if ((w_winner == OWN_D) && bus.d_wr) begin
              r_state    <= ST_WRITE;
              r_memWr    <= 1'b1;
              r_memAddr  <= {bus.d_addr[15:1], 1'b0};
              r_memWdata <= bus.d_wdata;
              r_dGrant   <= 1'b1;
              r_wrDone   <= 1'b1;
            end else begin
              r_state   <= ST_FILL;
              r_memWr   <= 1'b0;
              r_base    <= w_selBase;
              r_memAddr <= fill_addr(w_selBase, '0);
              r_iGrant  <= (w_winner == OWN_I);
              r_dGrant  <= (w_winner == OWN_D);
            end
          end
        end
        // Early responses can arrive while words are still being issued
        ST_FILL: begin
          if (r_issueCnt == LAST_IDX) begin
            r_memEn <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_issueCnt <= w_nextIssue;
            r_memAddr  <= fill_addr(r_base, w_nextIssue);
          end
          if (bus.mem_data_valid) begin
            r_recvCnt <= r_recvCnt + 1'b1;
            if (r_recvCnt == LAST_IDX) begin
              r_memEn <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.mem_data_valid) begin
            r_recvCnt <= r_recvCnt + 1'b1;
            if (r_recvCnt == LAST_IDX) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          r_memEn <= 1'b0;
          r_memWr <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  // Response routing uses only state and the registered owner
  assign w_busy = (r_state == ST_FILL) || (r_state == ST_DRAIN);
  assign w_rsp  = w_busy && bus.mem_data_valid;
  assign w_last = w_rsp && (r_recvCnt == LAST_IDX);

  assign bus.i_grant   = r_iGrant;
  assign bus.d_grant   = r_dGrant;
  assign bus.i_rvalid  = w_rsp && (r_owner == OWN_I);
  assign bus.d_rvalid  = w_rsp && (r_owner == OWN_D);
  assign bus.i_done    = w_last && (r_owner == OWN_I);
  assign bus.d_done    = (w_last && (r_owner == OWN_D)) || r_wrDone;
  assign bus.rdata     = w_busy ? bus.mem_rdata : '0;
  assign bus.rword     = r_recvCnt;
  assign bus.mem_en    = r_memEn;
  assign bus.mem_wr    = r_memWr;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter with a fixed-latency memory model.
module tb_cache_mem_arbiter;
  import cache_mem_pkg::*;

  localparam int MEM_LAT = 4;

  logic clk;
  logic rst_n;
  logic memRstN;
  int   nChecks;
  int   nFail;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS_PER_BLOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: a read accepted in cycle c answers in cycle c+MEM_LAT; not reset by rst_n
  logic        pipeV [MEM_LAT];
  logic [15:0] pipeA [MEM_LAT];

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (!memRstN) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipeV[i] <= 1'b0;
        pipeA[i] <= '0;
      end
    end else begin
      pipeV[0] <= bus.mem_en & ~bus.mem_wr;
      pipeA[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipeV[i] <= pipeV[i-1];
        pipeA[i] <= pipeA[i-1];
      end
    end
  end

  assign bus.mem_data_valid = pipeV[MEM_LAT-1];
  assign bus.mem_rdata      = pipeV[MEM_LAT-1] ? memWord(pipeA[MEM_LAT-1]) : 16'h0000;

  task automatic test_reset();
    int waitCnt;
    rst_n   = 1'b0;
    memRstN = 1'b0;
    repeat (2) @(negedge clk);
    memRstN = 1'b1;
    nChecks++;
    if ({bus.mem_en, bus.mem_wr, bus.i_grant, bus.d_grant, bus.i_rvalid, bus.d_rvalid,
         bus.i_done, bus.d_done} !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL reset_ctrl got %b want 00000000", {bus.mem_en, bus.mem_wr,
               bus.i_grant, bus.d_grant, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done});
    end
    nChecks++;
    if (bus.rword !== 3'd0 || bus.rdata !== 16'h0000) begin
      nFail++;
      $display("[TB] FAIL reset_data got rword=%0d rdata=%h want 0/0000", bus.rword, bus.rdata);
    end
    rst_n       = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0011;
    bus.d_wdata = 16'hCAFE;
    waitCnt = 0;
    while (waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
      if (bus.d_grant === 1'b1) break;
    end
    nChecks++;
    if (waitCnt !== MEM_LAT + 2) begin
      nFail++;
      $display("[TB] FAIL reset_first_grant got %0d cycles want %0d", waitCnt, MEM_LAT + 2);
    end
    nChecks++;
    if ({bus.mem_en, bus.mem_wr, bus.d_done} !== 3'b111 || bus.mem_addr !== 16'h0010 ||
        bus.mem_wdata !== 16'hCAFE) begin
      nFail++;
      $display("[TB] FAIL reset_write got en/wr/done=%b addr=%h wdata=%h want 111/0010/cafe",
               {bus.mem_en, bus.mem_wr, bus.d_done}, bus.mem_addr, bus.mem_wdata);
    end
    bus.d_req = 1'b0;
    bus.d_wr  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lone_ifill();
    int          waitCnt;
    logic [15:0] expA;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1236;
    waitCnt = 0;
    while (waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_grant === 1'b1) break;
    end
    nChecks++;
    if (waitCnt !== 1) begin
      nFail++;
      $display("[TB] FAIL ifill_grant_latency got %0d want 1", waitCnt);
    end
    bus.i_req = 1'b0;
    for (int cyc = 0; cyc <= MEM_LAT + 9; cyc++) begin
      if (cyc > 0) @(negedge clk);
      nChecks++;
      if (bus.i_grant !== (cyc == 0)) begin
        nFail++;
        $display("[TB] FAIL ifill_grant cyc=%0d got %b want %b", cyc, bus.i_grant, cyc == 0);
      end
      nChecks++;
      if (bus.mem_en !== (cyc < 8)) begin
        nFail++;
        $display("[TB] FAIL ifill_mem_en cyc=%0d got %b want %b", cyc, bus.mem_en, cyc < 8);
      end
      if (cyc < 8) begin
        expA = 16'h1230 + 16'(2 * cyc);
        nChecks++;
        if (bus.mem_addr !== expA || bus.mem_wr !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL ifill_addr cyc=%0d got %h wr=%b want %h wr=0", cyc, bus.mem_addr,
                   bus.mem_wr, expA);
        end
      end
      nChecks++;
      if (bus.i_rvalid !== (cyc >= MEM_LAT && cyc < MEM_LAT + 8)) begin
        nFail++;
        $display("[TB] FAIL ifill_rvalid cyc=%0d got %b", cyc, bus.i_rvalid);
      end
      if (cyc >= MEM_LAT && cyc < MEM_LAT + 8) begin
        expA = 16'h1230 + 16'(2 * (cyc - MEM_LAT));
        nChecks++;
        if (bus.rword !== 3'(cyc - MEM_LAT) || bus.rdata !== memWord(expA)) begin
          nFail++;
          $display("[TB] FAIL ifill_word cyc=%0d got rword=%0d rdata=%h want %0d/%h", cyc,
                   bus.rword, bus.rdata, cyc - MEM_LAT, memWord(expA));
        end
      end
      nChecks++;
      if (bus.i_done !== (cyc == MEM_LAT + 7)) begin
        nFail++;
        $display("[TB] FAIL ifill_done cyc=%0d got %b want %b", cyc, bus.i_done,
                 cyc == MEM_LAT + 7);
      end
      nChecks++;
      if ({bus.d_grant, bus.d_rvalid, bus.d_done} !== 3'b000) begin
        nFail++;
        $display("[TB] FAIL ifill_dside cyc=%0d got %b want 000", cyc,
                 {bus.d_grant, bus.d_rvalid, bus.d_done});
      end
    end
  endtask

  task automatic test_dwrite();
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0044;
    bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    nChecks++;
    if ({bus.d_grant, bus.d_done, bus.mem_en, bus.mem_wr, bus.d_rvalid} !== 5'b11110) begin
      nFail++;
      $display("[TB] FAIL dwrite_ctrl got grant/done/en/wr/rvalid=%b want 11110",
               {bus.d_grant, bus.d_done, bus.mem_en, bus.mem_wr, bus.d_rvalid});
    end
    nChecks++;
    if (bus.mem_addr !== 16'h0044 || bus.mem_wdata !== 16'hBEEF) begin
      nFail++;
      $display("[TB] FAIL dwrite_bus got addr=%h wdata=%h want 0044/beef", bus.mem_addr,
               bus.mem_wdata);
    end
    bus.d_req = 1'b0;
    bus.d_wr  = 1'b0;
    for (int cyc = 1; cyc <= MEM_LAT + 2; cyc++) begin
      @(negedge clk);
      nChecks++;
      if ({bus.mem_en, bus.d_grant, bus.d_done, bus.d_rvalid} !== 4'b0000) begin
        nFail++;
        $display("[TB] FAIL dwrite_after cyc=%0d got en/grant/done/rvalid=%b want 0000", cyc,
                 {bus.mem_en, bus.d_grant, bus.d_done, bus.d_rvalid});
      end
    end
  endtask

  task automatic test_req_during_fill();
    int          waitCnt;
    int          dSeen;
    int          iRvCnt;
    logic [15:0] expA;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h2000;
    waitCnt = 0;
    while (waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_grant === 1'b1) break;
    end
    bus.i_req = 1'b0;
    dSeen  = -1;
    iRvCnt = 0;
    for (int cyc = 0; cyc <= MEM_LAT + 14; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.d_grant === 1'b1) begin
        dSeen = cyc;
        break;
      end
      if (bus.i_rvalid === 1'b1) iRvCnt++;
      nChecks++;
      if (bus.d_rvalid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL midreq_misroute cyc=%0d got d_rvalid=%b want 0", cyc, bus.d_rvalid);
      end
      if (cyc == 3) begin
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 16'h300A;
      end
    end
    bus.d_req = 1'b0;
    nChecks++;
    if (dSeen !== MEM_LAT + 9) begin
      nFail++;
      $display("[TB] FAIL midreq_dgrant got cycle %0d want %0d", dSeen, MEM_LAT + 9);
    end
    nChecks++;
    if (iRvCnt !== 8) begin
      nFail++;
      $display("[TB] FAIL midreq_icount got %0d want 8", iRvCnt);
    end
    for (int j = 0; j <= MEM_LAT + 8; j++) begin
      if (j > 0) @(negedge clk);
      nChecks++;
      if (bus.d_rvalid !== (j >= MEM_LAT && j < MEM_LAT + 8) || bus.i_rvalid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL dfill_rvalid j=%0d got d=%b i=%b", j, bus.d_rvalid, bus.i_rvalid);
      end
      if (j >= MEM_LAT && j < MEM_LAT + 8) begin
        expA = 16'h3000 + 16'(2 * (j - MEM_LAT));
        nChecks++;
        if (bus.rword !== 3'(j - MEM_LAT) || bus.rdata !== memWord(expA)) begin
          nFail++;
          $display("[TB] FAIL dfill_word j=%0d got rword=%0d rdata=%h want %0d/%h", j,
                   bus.rword, bus.rdata, j - MEM_LAT, memWord(expA));
        end
      end
      nChecks++;
      if (bus.d_done !== (j == MEM_LAT + 7)) begin
        nFail++;
        $display("[TB] FAIL dfill_done j=%0d got %b want %b", j, bus.d_done, j == MEM_LAT + 7);
      end
    end
  endtask

  task automatic test_reset_midfill();
    int waitCnt;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h4000;
    waitCnt = 0;
    while (waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_grant === 1'b1) break;
    end
    bus.i_req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({bus.mem_en, bus.mem_wr, bus.i_grant, bus.d_grant, bus.i_rvalid, bus.d_rvalid,
         bus.i_done, bus.d_done} !== 8'h00 || bus.rword !== 3'd0) begin
      nFail++;
      $display("[TB] FAIL midrst_outputs got %b rword=%0d want 00000000/0", {bus.mem_en,
               bus.mem_wr, bus.i_grant, bus.d_grant, bus.i_rvalid, bus.d_rvalid, bus.i_done,
               bus.d_done}, bus.rword);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0050;
    bus.d_wdata = 16'h1234;
    waitCnt = 0;
    while (waitCnt < 20) begin
      nChecks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_done} !== 3'b000) begin
        nFail++;
        $display("[TB] FAIL midrst_stale w=%0d got i_rv/d_rv/i_done=%b want 000", waitCnt,
                 {bus.i_rvalid, bus.d_rvalid, bus.i_done});
      end
      @(negedge clk);
      waitCnt++;
      if (bus.d_grant === 1'b1) break;
    end
    nChecks++;
    if (waitCnt !== MEM_LAT + 2) begin
      nFail++;
      $display("[TB] FAIL midrst_first_grant got %0d cycles want %0d", waitCnt, MEM_LAT + 2);
    end
    bus.d_req = 1'b0;
    bus.d_wr  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    int waitCnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h6002;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h7004;
    waitCnt = 0;
    while (waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_grant === 1'b1 || bus.d_grant === 1'b1) break;
    end
    nChecks++;
    if ({bus.i_grant, bus.d_grant} !== 2'b10 || waitCnt !== MEM_LAT + 2) begin
      nFail++;
      $display("[TB] FAIL tie1_winner got i/d=%b after %0d want 10 after %0d",
               {bus.i_grant, bus.d_grant}, waitCnt, MEM_LAT + 2);
    end
    bus.i_req = 1'b0;
    waitCnt = 0;
    while (waitCnt < MEM_LAT + 14) begin
      @(negedge clk);
      waitCnt++;
      if (bus.d_grant === 1'b1) break;
    end
    nChecks++;
    if (waitCnt !== MEM_LAT + 9) begin
      nFail++;
      $display("[TB] FAIL tie1_dgrant got %0d cycles want %0d", waitCnt, MEM_LAT + 9);
    end
    bus.d_req = 1'b0;
    waitCnt = 0;
    while (waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
      if (bus.d_done === 1'b1) break;
    end
    nChecks++;
    if (waitCnt !== MEM_LAT + 7) begin
      nFail++;
      $display("[TB] FAIL tie1_ddone got %0d cycles want %0d", waitCnt, MEM_LAT + 7);
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h6100;
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h7100;
    waitCnt = 0;
    while (waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_grant === 1'b1 || bus.d_grant === 1'b1) break;
    end
    nChecks++;
    if ({bus.i_grant, bus.d_grant} !== 2'b10 || waitCnt !== 2) begin
      nFail++;
      $display("[TB] FAIL tie2_winner got i/d=%b after %0d want 10 after 2",
               {bus.i_grant, bus.d_grant}, waitCnt);
    end
    bus.i_req = 1'b0;
    waitCnt = 0;
    while (waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_done === 1'b1) break;
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h6200;
    waitCnt = 0;
    while (waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
      if (bus.i_grant === 1'b1 || bus.d_grant === 1'b1) break;
    end
    nChecks++;
    if ({bus.i_grant, bus.d_grant} !== 2'b01 || waitCnt !== 2) begin
      nFail++;
      $display("[TB] FAIL tie3_winner got i/d=%b after %0d want 01 after 2",
               {bus.i_grant, bus.d_grant}, waitCnt);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    waitCnt = 0;
    while (waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
      if (bus.d_done === 1'b1) break;
    end
    nChecks++;
    if (waitCnt !== MEM_LAT + 7) begin
      nFail++;
      $display("[TB] FAIL tie3_ddone got %0d cycles want %0d", waitCnt, MEM_LAT + 7);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    nChecks     = 0;
    nFail       = 0;
    rst_n       = 1'b0;
    memRstN     = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    test_reset();
    test_lone_ifill();
    test_dwrite();
    test_req_during_fill();
    test_reset_midfill();
    test_tie();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
